// File: rtl/tdm_pkg.sv
// Shared definitions for the 8-slot TDM link, used by both transmit and receive sides.
package tdm_pkg;
    localparam int N_SLOTS = 8;
    localparam int SLOT_W  = 3;

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } tdm_state_e;
endpackage

// File: rtl/contador_slot.sv
// Slot index counter: synchronous clear, load-to-1, increment, and a last-slot flag.
module contador_slot
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              load1_i,
    input  logic              inc_i,
    output logic [SLOT_W-1:0] slot_o,
    output logic              wrap_o
);
    logic [SLOT_W-1:0] slot_q, slot_d;

    // clear wins over load, load wins over increment
    always_comb begin
        slot_d = slot_q;
        if (clr_i)        slot_d = '0;
        else if (load1_i) slot_d = SLOT_W'(1);
        else if (inc_i)   slot_d = slot_q + SLOT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) slot_q <= '0;
        else        slot_q <= slot_d;
    end

    assign slot_o = slot_q;
    assign wrap_o = (slot_q == SLOT_W'(N_SLOTS - 1));
endmodule

// File: rtl/demux_tdm_1para8.sv
// 1:8 TDM receiver: reassembles 8-slot frames into parallel lanes with sync tracking.
module demux_tdm_1para8
    import tdm_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter bit SYNC_EVERY = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         din,
    input  logic                     din_valid,
    input  logic                     frame_sync,
    output logic [N_SLOTS*WIDTH-1:0] q,
    output logic                     frame_valid,
    output logic [SLOT_W-1:0]        slot,
    output logic                     locked,
    output logic                     sync_err
);
    tdm_state_e state_q, state_d;
    logic [N_SLOTS-2:0][WIDTH-1:0] shadow_q, shadow_d;
    logic [N_SLOTS*WIDTH-1:0]      q_q, q_d;
    logic                          fv_q, fv_d, err_q, err_d;
    logic                          clr, load1, inc, wrap;
    logic [SLOT_W-1:0]             slot_cur;

    contador_slot u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clr),
        .load1_i (load1),
        .inc_i   (inc),
        .slot_o  (slot_cur),
        .wrap_o  (wrap)
    );

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        q_d      = q_q;
        fv_d     = 1'b0;
        err_d    = 1'b0;
        clr      = 1'b0;
        load1    = 1'b0;
        inc      = 1'b0;
        if (din_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        shadow_d[0] = din;
                        load1       = 1'b1;
                        state_d     = RECV;
                    end
                end
                RECV: begin
                    if (frame_sync && slot_cur != '0) begin
                        // early sync restarts the frame on this beat
                        err_d       = 1'b1;
                        shadow_d[0] = din;
                        load1       = 1'b1;
                    end else if (!frame_sync && slot_cur == '0 && SYNC_EVERY) begin
                        err_d   = 1'b1;
                        clr     = 1'b1;
                        state_d = HUNT;
                    end else if (wrap) begin
                        q_d  = {din, shadow_q};
                        fv_d = 1'b1;
                        clr  = 1'b1;
                    end else begin
                        shadow_d[slot_cur] = din;
                        inc                = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            shadow_q <= '0;
            q_q      <= '0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            q_q      <= q_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
        end
    end

    assign q           = q_q;
    assign frame_valid = fv_q;
    assign slot        = slot_cur;
    assign locked      = (state_q == RECV);
    assign sync_err    = err_q;
endmodule

// File: tb/tb_demux_tdm_1para8.sv
// Directed bench for the 1:8 TDM receiver, with SYNC_EVERY=1 and SYNC_EVERY=0 instances.
module tb_demux_tdm_1para8;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [0:0] din;
    logic       din_valid, frame_sync;

    logic [7:0] q1, q0;
    logic       fv1, fv0, lk1, lk0, er1, er0;
    logic [2:0] sl1, sl0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_tdm_1para8 #(.WIDTH(1), .SYNC_EVERY(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
        .q(q1), .frame_valid(fv1), .slot(sl1), .locked(lk1), .sync_err(er1)
    );

    demux_tdm_1para8 #(.WIDTH(1), .SYNC_EVERY(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
        .q(q0), .frame_valid(fv0), .slot(sl0), .locked(lk0), .sync_err(er0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // apply one cycle of inputs, then sample just after the edge
    task automatic step(input logic v, input logic s, input logic d);
        din_valid  = v;
        frame_sync = s;
        din        = d;
        @(posedge clk);
        #1;
    endtask

    // full frame into a locked receiver, optional idle gap after slot 2
    task automatic send_frame(input logic [7:0] lanes, input logic [7:0] q_prev, input int gap);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, k == 0, lanes[k]);
            if (k < 7) begin
                chk("fv_mid", fv1, 0);
                chk("q_hold", q1, q_prev);
            end
            if (k == 2)
                for (int g = 0; g < gap; g++) begin
                    step(1'b0, 1'b0, 1'b0);
                    chk("fv_gap", fv1, 0);
                    chk("slot_gap", sl1, 3);
                end
        end
        chk("fv_end", fv1, 1);
        chk("q_end", q1, lanes);
        chk("slot_wrap", sl1, 0);
        chk("err_end", er1, 0);
    endtask

    initial begin
        logic [7:0] lanes;
        rst_n = 1'b0; din = '0; din_valid = 1'b0; frame_sync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", q1, 0);
        chk("rst_fv", fv1, 0);
        chk("rst_slot", sl1, 0);
        chk("rst_lock", lk1, 0);
        chk("rst_err", er1, 0);
        rst_n = 1'b1;

        // HUNT ignores unsynced beats and sync without valid
        step(1'b1, 1'b0, 1'b1);
        chk("hunt_nosync_lock", lk1, 0);
        chk("hunt_nosync_slot", sl1, 0);
        step(1'b0, 1'b1, 1'b1);
        chk("sync_novalid_lock", lk1, 0);

        // 1 acquire
        step(1'b1, 1'b1, 1'b1);
        chk("acq_lock", lk1, 1);
        chk("acq_slot", sl1, 1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("acq_slot7", sl1, 7);
        chk("acq_fv_pre", fv1, 0);
        step(1'b1, 1'b0, 1'b0);
        chk("acq_fv", fv1, 1);
        chk("acq_q", q1, 8'h4D);
        chk("acq_slot0", sl1, 0);
        chk("acq_lock1", lk1, 1);
        step(1'b0, 1'b0, 1'b0);
        chk("acq_fv_pulse", fv1, 0);
        chk("acq_q_hold", q1, 8'h4D);

        // 2 gaps
        send_frame(8'h4D, 8'h4D, 3);
        step(1'b0, 1'b0, 1'b0);
        chk("gap_fv_pulse", fv1, 0);

        // 3 early sync at slot 5
        for (int k = 0; k < 5; k++) step(1'b1, k == 0, 1'b1);
        chk("es_slot5", sl1, 5);
        step(1'b1, 1'b1, 1'b0);
        chk("es_err", er1, 1);
        chk("es_err0", er0, 1);
        chk("es_slot", sl1, 1);
        chk("es_fv", fv1, 0);
        chk("es_q", q1, 8'h4D);
        lanes = 8'hC6;
        for (int k = 1; k < 8; k++) begin
            step(1'b1, 1'b0, lanes[k]);
            if (k == 1) chk("es_err_pulse", er1, 0);
            if (k == 6) chk("es_q_hold", q1, 8'h4D);
        end
        chk("es_fv_end", fv1, 1);
        chk("es_q_end", q1, 8'hC6);
        chk("es_q0_end", q0, 8'hC6);

        // 4 missing sync
        lanes = 8'h81;
        step(1'b1, 1'b0, lanes[0]);
        chk("ms_err", er1, 1);
        chk("ms_lock", lk1, 0);
        chk("ms_slot", sl1, 0);
        chk("ms_err0", er0, 0);
        chk("ms_slot0", sl0, 1);
        for (int k = 1; k < 8; k++) step(1'b1, 1'b0, lanes[k]);
        chk("ms_ign_lock", lk1, 0);
        chk("ms_ign_slot", sl1, 0);
        chk("ms_ign_fv", fv1, 0);
        chk("ms_ign_q", q1, 8'hC6);
        chk("ms_fv0", fv0, 1);
        chk("ms_q0", q0, 8'h81);
        send_frame(8'hAA, 8'hC6, 0);
        chk("ms_req_q0", q0, 8'hAA);
        chk("ms_req_lock", lk1, 1);

        // 5 reset at slot 4
        for (int k = 0; k < 4; k++) step(1'b1, k == 0, 1'b1);
        chk("rs_slot4", sl1, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_q", q1, 0);
        chk("rs_fv", fv1, 0);
        chk("rs_slot", sl1, 0);
        chk("rs_lock", lk1, 0);
        chk("rs_err", er1, 0);
        #2 rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        chk("rs_nosync_lock", lk1, 0);
        chk("rs_nosync_fv", fv1, 0);
        step(1'b1, 1'b1, 1'b1);
        chk("rs_reacq_lock", lk1, 1);
        chk("rs_reacq_slot", sl1, 1);

        // 6 loopback: counter-driven 8:1 mux transmitter, continuous frames
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int f = 0; f < 100; f++) begin
            lanes = 8'($urandom);
            for (int tx_cnt = 0; tx_cnt < 8; tx_cnt++) begin
                step(1'b1, tx_cnt == 0, lanes[tx_cnt]);
                chk("lb_err", er1, 0);
                chk("lb_fv", fv1, (tx_cnt == 7) ? 32'd1 : 32'd0);
                if (tx_cnt == 7) chk("lb_q", q1, lanes);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
